// File: rtl/fec_frame_sync_pkg.sv
// fec_pkg: shared FSM state encoding and default sizing constants for FEC block sync.
package fec_pkg;
    typedef enum logic [1:0] {ST_HUNT, ST_CONFIRM, ST_LOCKED, ST_SLIP_WAIT} fec_state_e;
    localparam int FEC_FRAME_WORDS   = 66;
    localparam int FEC_GOOD_TO_LOCK  = 4;
    localparam int FEC_BAD_TO_UNLOCK = 8;
    localparam int FEC_SLIP_WAIT     = 4;
endpackage

// File: rtl/fec_frame_sync_word_ctr.sv
// fec_word_ctr: word position within the candidate block; wraps at FRAME_WORDS-1, clr_i forces 0.
module fec_word_ctr #(
    parameter int FRAME_WORDS = 66
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       clr_i,
    output logic [6:0] idx_o
);
    logic [6:0] idx_q, idx_d;

    always_comb idx_d = (clr_i || idx_q == 7'(FRAME_WORDS - 1)) ? '0 : idx_q + 7'd1;

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) idx_q <= '0;
        else         idx_q <= idx_d;

    assign idx_o = idx_q;
endmodule

// File: rtl/fec_frame_sync.sv
// fec_frame_sync: FEC block lock FSM driving word position, sof/eof, gearbox slip and lock status.
// Optional FEC_FRAME_SYNC_STATS_EN adds saturating slip_count / lock_loss_count outputs.
module fec_frame_sync
    import fec_pkg::*;
#(
    parameter int FRAME_WORDS   = FEC_FRAME_WORDS,
    parameter int GOOD_TO_LOCK  = FEC_GOOD_TO_LOCK,
    parameter int BAD_TO_UNLOCK = FEC_BAD_TO_UNLOCK,
    parameter int SLIP_WAIT     = FEC_SLIP_WAIT
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        check_done,
    input  logic        parity_match,
    output logic        sof,
    output logic        eof,
    output logic [6:0]  word_idx,
    output logic        slip,
    output logic        locked
`ifdef FEC_FRAME_SYNC_STATS_EN
    ,
    output logic [15:0] slip_count,
    output logic [15:0] lock_loss_count
`endif
);
    localparam int GW = $clog2(GOOD_TO_LOCK + 1);
    localparam int BW = $clog2(BAD_TO_UNLOCK + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);

    fec_state_e    state_q, state_d;
    logic [GW-1:0] good_q, good_d, good_inc;
    logic [BW-1:0] bad_q, bad_d, bad_inc;
    logic [WW-1:0] wait_q, wait_d;
    logic          blank_q, blank_d, valid;

    fec_word_ctr #(.FRAME_WORDS(FRAME_WORDS)) u_ctr (
        .clk    (clk),
        .arst_n (arst_n),
        .clr_i  (state_q == ST_SLIP_WAIT || state_d == ST_SLIP_WAIT),
        .idx_o  (word_idx)
    );

    assign sof    = word_idx == 7'd0 && state_q != ST_SLIP_WAIT;
    assign eof    = word_idx == 7'(FRAME_WORDS - 1);
    assign locked = state_q == ST_LOCKED;
    assign slip   = state_q == ST_SLIP_WAIT && wait_q == '0;
    // Results during the realign wait and the first block after it judge the old alignment.
    assign valid    = check_done && !blank_q;
    assign good_inc = (good_q == GW'(GOOD_TO_LOCK)) ? good_q : good_q + GW'(1);
    assign bad_inc  = (bad_q == BW'(BAD_TO_UNLOCK)) ? bad_q : bad_q + BW'(1);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        case (state_q)
            ST_HUNT, ST_CONFIRM: if (valid) begin
                good_d  = good_inc;
                state_d = !parity_match ? ST_SLIP_WAIT :
                          (good_inc == GW'(GOOD_TO_LOCK)) ? ST_LOCKED : ST_CONFIRM;
            end
            ST_LOCKED: if (valid) begin
                bad_d   = parity_match ? '0 : bad_inc;
                state_d = (!parity_match && bad_inc == BW'(BAD_TO_UNLOCK)) ? ST_SLIP_WAIT : ST_LOCKED;
            end
            default: state_d = (wait_q == WW'(SLIP_WAIT - 1)) ? ST_HUNT : ST_SLIP_WAIT;
        endcase
        wait_d = (state_q == ST_SLIP_WAIT && state_d == ST_SLIP_WAIT) ? wait_q + WW'(1) : '0;
        if (state_d == ST_SLIP_WAIT) begin
            good_d = '0;
            bad_d  = '0;
        end
        blank_d = state_d == ST_SLIP_WAIT || (blank_q && !eof);
    end

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            state_q <= ST_HUNT;
            good_q  <= '0;
            bad_q   <= '0;
            wait_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            wait_q  <= wait_d;
            blank_q <= blank_d;
        end

`ifdef FEC_FRAME_SYNC_STATS_EN
    logic [15:0] slip_count_q, lock_loss_count_q;
    logic        lock_loss;

    assign lock_loss = state_q == ST_LOCKED && state_d == ST_SLIP_WAIT;

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            slip_count_q      <= '0;
            lock_loss_count_q <= '0;
        end else begin
            slip_count_q      <= (slip && slip_count_q != 16'hFFFF) ? slip_count_q + 16'd1 : slip_count_q;
            lock_loss_count_q <= (lock_loss && lock_loss_count_q != 16'hFFFF) ?
                                 lock_loss_count_q + 16'd1 : lock_loss_count_q;
        end

    assign slip_count      = slip_count_q;
    assign lock_loss_count = lock_loss_count_q;
`endif
endmodule

// File: tb/tb_fec_frame_sync.sv
// tb_fec_frame_sync: directed block results; expected slip/lock events queued and matched by a monitor.
module tb_fec_frame_sync;
    localparam int K_NONE = 0, K_SLIP = 1, K_LOCK = 2, K_UNLOCK = 3;

    logic       clk = 1'b0, arst_n = 1'b0, check_done = 1'b0, parity_match = 1'b0;
    logic       sof, eof, slip, locked;
    logic [6:0] word_idx;
`ifdef FEC_FRAME_SYNC_STATS_EN
    logic [15:0] slip_count, lock_loss_count;
`endif

    typedef struct {int kind; int cyc;} ev_t;
    ev_t exp_q[$];
    int  checks = 0, errors = 0, cyc = 0, exp_slips = 0, exp_losses = 0;
    logic prev_locked = 1'b0, prev_slip = 1'b0;

    fec_frame_sync dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .check_done   (check_done),
        .parity_match (parity_match),
        .sof          (sof),
        .eof          (eof),
        .word_idx     (word_idx),
        .slip         (slip),
        .locked       (locked)
`ifdef FEC_FRAME_SYNC_STATS_EN
        ,
        .slip_count      (slip_count),
        .lock_loss_count (lock_loss_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic match(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got kind %0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                         kind, cyc, e.kind, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (arst_n) begin
            if (slip && prev_slip) begin
                errors++;
                $display("FAIL slip_back_to_back: got 1 on consecutive cycles at %0d, required 0", cyc);
            end
            if (locked && !prev_locked) match(K_LOCK);
            if (!locked && prev_locked) match(K_UNLOCK);
            if (slip) match(K_SLIP);
        end
        prev_locked = locked;
        prev_slip   = slip;
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push(input int kind);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        if (kind == K_SLIP) exp_slips++;
        if (kind == K_UNLOCK) exp_losses++;
    endtask

    task automatic wait_idx(input int k);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (word_idx == 7'(k)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idx: got no word_idx %0d within 300 cycles, required it", k);
    endtask

    task automatic blk(input logic pm, input int kind);
        wait_idx(2);
        check_done   = 1'b1;
        parity_match = pm;
        if (kind == K_UNLOCK) begin
            push(K_UNLOCK);
            push(K_SLIP);
        end else if (kind != K_NONE) push(kind);
        @(negedge clk);
        check_done   = 1'b0;
        parity_match = 1'($urandom);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sof", int'(sof), 1);
        chk("rst_eof", int'(eof), 0);
        chk("rst_idx", int'(word_idx), 0);
        chk("rst_slip", int'(slip), 0);
        chk("rst_locked", int'(locked), 0);
        #2 arst_n = 1'b1;
        @(negedge clk);
        chk("first_edge_idx", int'(word_idx), 1);
        repeat (3) blk(1'b1, K_NONE);
        blk(1'b1, K_LOCK);
        wait_idx(65);
        chk("eof_at_last", int'(eof), 1);
        chk("sof_at_last", int'(sof), 0);
        @(negedge clk);
        chk("wrap_idx", int'(word_idx), 0);
        chk("wrap_sof", int'(sof), 1);
        repeat (7) blk(1'b0, K_NONE);
        blk(1'b1, K_NONE);
        repeat (7) blk(1'b0, K_NONE);
        blk(1'b1, K_NONE);
        repeat (7) blk(1'b0, K_NONE);
        blk(1'b0, K_UNLOCK);
        chk("unlocked", int'(locked), 0);
        blk(1'b0, K_NONE);
        blk(1'b0, K_SLIP);
        for (int i = 0; i < 4; i++) begin
            chk("hold_idx", int'(word_idx), 0);
            chk("hold_sof", int'(sof), 0);
            @(negedge clk);
        end
        chk("resume_sof", int'(sof), 1);
        chk("resume_idx", int'(word_idx), 0);
        blk(1'b0, K_NONE);
        blk(1'b1, K_NONE);
        blk(1'b1, K_NONE);
        blk(1'b0, K_SLIP);
        chk("confirm_fail_locked", int'(locked), 0);
        blk(1'b0, K_NONE);
        blk(1'b0, K_SLIP);
        blk(1'b0, K_NONE);
        blk(1'b0, K_SLIP);
        blk(1'b0, K_NONE);
        repeat (3) blk(1'b1, K_NONE);
        blk(1'b1, K_LOCK);
`ifdef FEC_FRAME_SYNC_STATS_EN
        chk("slip_count", int'(slip_count), exp_slips);
        chk("lock_loss_count", int'(lock_loss_count), exp_losses);
`endif
        wait_idx(30);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_slip", int'(slip), 0);
        chk("arst_idx", int'(word_idx), 0);
        chk("arst_sof", int'(sof), 1);
        chk("arst_eof", int'(eof), 0);
        @(negedge clk);
        #2 arst_n = 1'b1;
        @(negedge clk);
        chk("rerelease_idx", int'(word_idx), 1);
        repeat (3) blk(1'b1, K_NONE);
        blk(1'b1, K_LOCK);
        repeat (3) @(negedge clk);
        while (exp_q.size() != 0) begin
            ev_t e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got nothing, required kind %0d at cycle %0d", e.kind, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
